// File: rtl/score_hex_display.sv
// Converts the binary game score into four active-low 7-segment digits with an
// iterative double-dabble FSM; GAME_OVER and WIN states show fixed text instead.
module score_hex_display #(
  parameter int LZ_BLANK = 1,
  parameter int MAX_SHOW = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        update,
  input  logic [15:0] score,
  input  logic [2:0]  game_state,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic        busy,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [15:0] MAX_VAL   = 16'(MAX_SHOW);
  localparam logic [6:0]  SEG_ZERO  = 7'b1000000;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [6:0]  BLANK_RST = (LZ_BLANK != 0) ? SEG_BLANK : SEG_ZERO;

  state_t           state_reg, state_next;
  logic [15:0]      snap_reg, snap_next;
  logic [15:0]      bcd_reg, bcd_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [2:0]       st_reg, st_next;
  logic             busy_reg, busy_next;
  logic             ovf_reg, ovf_next;
  logic             pending_reg, pending_next;
  logic [3:0][6:0]  hex_reg, hex_next;

  logic [15:0]      bcd_adj;
  logic [31:0]      shifted;
  logic [3:0]       nib_zero;
  logic [3:0]       lead_blank;
  logic [3:0][6:0]  score_seg;
  logic [3:0][6:0]  disp_seg;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Per-nibble add-3 correction, zero detect and digit decode.
  for (genvar gi = 0; gi < 4; gi++) begin : g_nib
    logic [3:0] nib;
    assign nib                = bcd_reg[gi*4 +: 4];
    assign bcd_adj[gi*4 +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    assign nib_zero[gi]       = (nib == 4'd0);
    if (gi == 0) begin : g_units
      assign lead_blank[gi] = 1'b0;
    end else begin : g_upper
      assign lead_blank[gi] = &nib_zero[3:gi];
    end
    assign score_seg[gi] = ((LZ_BLANK != 0) && lead_blank[gi]) ? SEG_BLANK : seg7(nib);
  end

  assign shifted = {bcd_adj, snap_reg} << 1;

  always_comb begin
    case (st_reg)
      3'd1:    disp_seg = {7'b0100001, 7'b0000110, 7'b0001000, 7'b0100001};
      3'd2:    disp_seg = {7'b0100001, 7'b0100011, 7'b0101011, 7'b0000110};
      default: disp_seg = score_seg;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    snap_next    = snap_reg;
    bcd_next     = bcd_reg;
    cnt_next     = cnt_reg;
    st_next      = st_reg;
    busy_next    = busy_reg;
    ovf_next     = ovf_reg;
    pending_next = pending_reg;
    hex_next     = hex_reg;
    case (state_reg)
      IDLE: begin
        if (update || pending_reg) begin
          snap_next    = (score > MAX_VAL) ? MAX_VAL : score;
          st_next      = game_state;
          ovf_next     = (score > MAX_VAL);
          bcd_next     = '0;
          cnt_next     = '0;
          busy_next    = 1'b1;
          pending_next = 1'b0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        bcd_next  = shifted[31:16];
        snap_next = shifted[15:0];
        cnt_next  = cnt_reg + 4'd1;
        if (update) pending_next = 1'b1;
        if (cnt_reg == 4'd15) state_next = DONE;
      end
      DONE: begin
        // Requests seen here are still folded into pending and served next edge.
        hex_next   = disp_seg;
        busy_next  = 1'b0;
        state_next = IDLE;
        if (update) pending_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      snap_reg    <= '0;
      bcd_reg     <= '0;
      cnt_reg     <= '0;
      st_reg      <= '0;
      busy_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
      pending_reg <= 1'b0;
      hex_reg     <= {BLANK_RST, BLANK_RST, BLANK_RST, SEG_ZERO};
    end else begin
      state_reg   <= state_next;
      snap_reg    <= snap_next;
      bcd_reg     <= bcd_next;
      cnt_reg     <= cnt_next;
      st_reg      <= st_next;
      busy_reg    <= busy_next;
      ovf_reg     <= ovf_next;
      pending_reg <= pending_next;
      hex_reg     <= hex_next;
    end
  end

  assign hex0     = hex_reg[0];
  assign hex1     = hex_reg[1];
  assign hex2     = hex_reg[2];
  assign hex3     = hex_reg[3];
  assign busy     = busy_reg;
  assign overflow = ovf_reg;

endmodule
